// File: rtl/riscv_pkg.sv
// Shared fetch-side types: NOP encoding, buffer entry layout, FSM states.
// Entry fields are sized for the widest supported XLEN/instruction width.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      HALT
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// In-order responses, one per accepted request, latency of at least one cycle.
interface instruction_fetch_if #(
   parameter int XLEN = 64,
   parameter int ILEN = 32
) ();

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [ILEN-1:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );

endinterface

// File: rtl/fetch_buffer.sv
// Prefetch FIFO of {pc, instr} entries with flush and same-cycle push/pop.
// DEPTH must be a power of two so the pointers wrap for free.
module fetch_buffer
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  fetch_entry_t entry_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output fetch_entry_t head_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [AW:0]  count_o
);

   localparam logic [AW:0] FULL_C = (AW + 1)'(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] rd_q, rd_d;
   logic [AW-1:0] wr_q, wr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push;
   logic          do_pop;

   always_comb begin
      do_pop  = pop_i && (cnt_q != '0);
      do_push = push_i && ((cnt_q != FULL_C) || do_pop);
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      if (flush_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_pop)
            rd_d = rd_q + AW'(1);
         if (do_push)
            wr_d = wr_q + AW'(1);
         cnt_d = cnt_q + (AW + 1)'(do_push)
                       - (AW + 1)'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i)
         mem_q[wr_q] <= entry_i;
   end

   assign head_o  = mem_q[rd_q];
   assign full_o  = (cnt_q == FULL_C);
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: credit-limited PC requests, prefetch buffer, redirect drain.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect traps into HALT instead of masking.
module instruction_fetch
   import riscv_pkg::*;
#(
   parameter int              XLEN               = 64,
   parameter int              INSTRUCTION_LENGTH = XLEN / 2,
   parameter logic [XLEN-1:0] RESET_VECTOR       = '0,
   parameter int              FETCH_DEPTH        = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   instruction_fetch_if.master           imem,
   input  logic                          redirect_valid,
   input  logic [XLEN-1:0]               redirect_target,
   input  logic                          f_to_d_enable_ff,
   output logic [INSTRUCTION_LENGTH-1:0] instruction,
   output logic [XLEN-1:0]               fetch_pc,
   output logic                          fetch_valid,
   output logic                          misaligned_fault
);

   localparam int CW = $clog2(FETCH_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FETCH_DEPTH);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   count;
   logic [CW:0]     used;
   logic [CW:0]     avail;
   logic [XLEN-1:0] target;
   logic            bad_tgt;
   logic            req_fire;
   logic            rsp_in;
   logic            pop;
   logic            push;
   logic            flush;
   logic            full;
   logic            empty;
   fetch_entry_t    head;
   fetch_entry_t    push_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic fault_q;

   assign target  = redirect_target;
   assign bad_tgt = |redirect_target[1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         fault_q <= 1'b0;
      else if (redirect_valid && bad_tgt)
         fault_q <= 1'b1;
   end

   assign misaligned_fault = fault_q;
`else
   assign target           = redirect_target & ~XLEN'(3);
   assign bad_tgt          = 1'b0;
   assign misaligned_fault = 1'b0;
`endif

   // A slot freed by this cycle's pop may be reissued at once.
   assign used  = {1'b0, outst_q} + {1'b0, count};
   assign avail = {1'b0, DEPTH_C} + (CW + 1)'(pop);

   assign imem.imem_req_valid = rst && (state_q == RUN)
                              && (used < avail)
                              && (!full || pop);
   assign imem.imem_req_addr  = pc_q;

   assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
   assign rsp_in   = imem.imem_rsp_valid;
   assign pop      = fetch_valid && f_to_d_enable_ff;

   always_comb begin
      push_entry = '0;
      push_entry.pc[XLEN-1:0] = rsp_pc_q;
      push_entry.instr[INSTRUCTION_LENGTH-1:0] =
         imem.imem_rsp_data;
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      rsp_pc_d = rsp_pc_q;
      outst_d  = outst_q + CW'(req_fire) - CW'(rsp_in);
      drop_d   = drop_q;
      push     = 1'b0;
      flush    = 1'b0;
      if (redirect_valid) begin
         flush    = 1'b1;
         pc_d     = target;
         rsp_pc_d = target;
         drop_d   = outst_d;
         if (bad_tgt)
            state_d = HALT;
         else if (outst_d != '0)
            state_d = DRAIN;
         else
            state_d = RUN;
      end else begin
         unique case (state_q)
            RUN: begin
               if (req_fire)
                  pc_d = pc_q + XLEN'(4);
               if (rsp_in) begin
                  push     = 1'b1;
                  rsp_pc_d = rsp_pc_q + XLEN'(4);
               end
            end
            DRAIN: begin
               if (rsp_in && drop_q != '0)
                  drop_d = drop_q - CW'(1);
               if (drop_d == '0)
                  state_d = RUN;
            end
            HALT: begin
               if (rsp_in && drop_q != '0)
                  drop_d = drop_q - CW'(1);
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RUN;
         pc_q     <= RESET_VECTOR;
         rsp_pc_q <= RESET_VECTOR;
         outst_q  <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
      end
   end

   fetch_buffer #(
      .DEPTH (FETCH_DEPTH)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .entry_i (push_entry),
      .pop_i   (pop),
      .flush_i (flush),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   assign fetch_valid = !empty;
   assign instruction = empty
      ? INSTRUCTION_LENGTH'(NOP_INSTR)
      : head.instr[INSTRUCTION_LENGTH-1:0];
   assign fetch_pc = empty ? '0 : head.pc[XLEN-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: latency-programmable imem model plus a
// scoreboard of expected {pc, instr} pairs checked as decode consumes them.
module tb_instruction_fetch;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } exp_t;

   typedef struct packed {
      logic [63:0] a;
      int          t;
   } pend_t;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [63:0] redirect_target;
   logic        f_to_d_enable_ff;
   logic [31:0] instruction;
   logic [63:0] fetch_pc;
   logic        fetch_valid;
   logic        misaligned_fault;

   logic        m_ready;
   logic        m_rsp_valid;
   logic [31:0] m_rsp_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat = 1;

   exp_t        exp_q[$];
   pend_t       pend[$];
   logic [63:0] issued[$];
   int          issued_cyc[$];
   logic [63:0] next_addr;
   logic [63:0] tgt_model;
   logic        halted;
   logic        halted_n;

   instruction_fetch_if #(.XLEN(64), .ILEN(32)) ifc ();

   assign ifc.imem_req_ready = m_ready;
   assign ifc.imem_rsp_valid = m_rsp_valid;
   assign ifc.imem_rsp_data  = m_rsp_data;

   instruction_fetch #(
      .XLEN               (64),
      .INSTRUCTION_LENGTH (32),
      .RESET_VECTOR       (64'h0),
      .FETCH_DEPTH        (2)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .imem             (ifc),
      .redirect_valid   (redirect_valid),
      .redirect_target  (redirect_target),
      .f_to_d_enable_ff (f_to_d_enable_ff),
      .instruction      (instruction),
      .fetch_pc         (fetch_pc),
      .fetch_valid      (fetch_valid),
      .misaligned_fault (misaligned_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mdata(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, want);
      end
   endtask

   // One clock: present memory response, score outputs, advance the edge.
   task automatic cycle();
      logic        fire;
      logic [63:0] fa;
      if (pend.size() > 0 && (cyc - pend[0].t) >= lat - 1) begin
         m_rsp_valid = 1'b1;
         m_rsp_data  = mdata(pend[0].a);
      end else begin
         m_rsp_valid = 1'b0;
         m_rsp_data  = '0;
      end
      #1;
      fire = ifc.imem_req_valid && ifc.imem_req_ready;
      fa   = ifc.imem_req_addr;
      if (fetch_valid) begin
         if (exp_q.size() == 0)
            chk("spurious", 64'(fetch_valid), 64'h0);
         else begin
            chk("pc", fetch_pc, exp_q[0].pc);
            chk("instr", 64'(instruction), 64'(exp_q[0].instr));
            if (f_to_d_enable_ff && !redirect_valid)
               void'(exp_q.pop_front());
         end
      end
      if (halted)
         chk("halt_req", 64'(ifc.imem_req_valid), 64'h0);
      if (fire) begin
         chk("addr", fa, next_addr);
         issued.push_back(fa);
         issued_cyc.push_back(cyc);
      end
      if (redirect_valid) begin
         exp_q.delete();
         next_addr = tgt_model;
         halted    = halted_n;
      end else if (fire) begin
         exp_q.push_back('{pc: fa, instr: mdata(fa)});
         next_addr = next_addr + 64'd4;
      end
      @(posedge clk);
      cyc++;
      if (m_rsp_valid)
         void'(pend.pop_front());
      if (fire)
         pend.push_back('{a: fa, t: cyc});
      @(negedge clk);
   endtask

   task automatic do_redirect(input logic [63:0] t);
      redirect_valid  = 1'b1;
      redirect_target = t;
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt_model = t;
      halted_n  = (t[1:0] != 2'b00);
`else
      tgt_model = t & ~64'h3;
      halted_n  = 1'b0;
`endif
      cycle();
      redirect_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input logic [63:0] pc);
      int n;
      n = 0;
      while (!fetch_valid && n < 40) begin
         cycle();
         n++;
      end
      chk(tag, fetch_pc, pc);
      chk({tag, "_v"}, 64'(fetch_valid), 64'h1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++)
         cycle();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_reqv"}, 64'(ifc.imem_req_valid), 64'h0);
      chk({tag, "_fv"}, 64'(fetch_valid), 64'h0);
      chk({tag, "_nop"}, 64'(instruction), 64'h13);
      chk({tag, "_pc"}, fetch_pc, 64'h0);
      chk({tag, "_fault"}, 64'(misaligned_fault), 64'h0);
   endtask

   initial begin
      int n;
      int n0;
      rst              = 1'b1;
      redirect_valid   = 1'b0;
      redirect_target  = '0;
      f_to_d_enable_ff = 1'b1;
      m_ready          = 1'b1;
      m_rsp_valid      = 1'b0;
      m_rsp_data       = '0;
      next_addr        = '0;
      tgt_model        = '0;
      halted           = 1'b0;
      halted_n         = 1'b0;
      #1 rst = 1'b0;
      #1 chk_reset_outputs("rst");

      // Release and check start-up latency.
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("first_reqv", 64'(ifc.imem_req_valid), 64'h1);
      chk("first_addr", ifc.imem_req_addr, 64'h0);
      chk("fv_c1", 64'(fetch_valid), 64'h0);
      cycle();
      chk("fv_c2", 64'(fetch_valid), 64'h0);
      cycle();
      chk("fv_c3", 64'(fetch_valid), 64'h1);
      run(6);
      chk("iss0", issued[0], 64'h0);
      chk("iss1", issued[1], 64'h4);
      chk("iss2", issued[2], 64'h8);
      chk("b2b1", 64'(issued_cyc[1] - issued_cyc[0]), 64'h1);
      chk("b2b2", 64'(issued_cyc[2] - issued_cyc[1]), 64'h1);

      // Decode stall: credits cap in-flight work, head holds.
      f_to_d_enable_ff = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("credit", 64'(exp_q.size() <= 2), 64'h1);
      end
      chk("stall_fv", 64'(fetch_valid), 64'h1);
      f_to_d_enable_ff = 1'b1;
      run(8);

      // Redirect with two requests in flight.
      lat = 3;
      n = 0;
      while (pend.size() < 2 && n < 20) begin
         cycle();
         n++;
      end
      chk("two_outst", 64'(pend.size()), 64'h2);
      do_redirect(64'h100);
      chk("flushed", 64'(fetch_valid), 64'h0);
      wait_valid("redir", 64'h100);
      run(8);

      // Memory back-pressure: address holds, one acceptance on release.
      lat = 1;
      run(4);
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("stable_addr", ifc.imem_req_addr, next_addr);
      end
      chk("hold_valid", 64'(ifc.imem_req_valid), 64'h1);
      m_ready = 1'b1;
      n0 = issued.size();
      cycle();
      chk("one_accept", 64'(issued.size() - n0), 64'h1);
      run(6);

      // Misaligned redirect target.
      do_redirect(64'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("fault_set", 64'(misaligned_fault), 64'h1);
      run(5);
      chk("halt_fv", 64'(fetch_valid), 64'h0);
      do_redirect(64'h200);
      wait_valid("resume", 64'h200);
      chk("fault_sticky", 64'(misaligned_fault), 64'h1);
`else
      wait_valid("masked", 64'h100);
`endif
      run(6);

      // Asynchronous reset while draining.
      lat = 3;
      n = 0;
      while (pend.size() < 1 && n < 20) begin
         cycle();
         n++;
      end
      do_redirect(64'h300);
      chk("drain_entry", 64'(pend.size() > 0), 64'h1);
      #2 rst = 1'b0;
      #1 chk_reset_outputs("mid_rst");
      pend.delete();
      exp_q.delete();
      next_addr   = '0;
      halted      = 1'b0;
      m_rsp_valid = 1'b0;
      lat         = 1;
      @(negedge clk);
      rst = 1'b1;
      wait_valid("restart", 64'h0);
      run(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath/PC width.
REQ-002 SHALL have parameter INSTRUCTION_LENGTH, default XLEN/2, instruction width.
REQ-003 SHALL have parameter RESET_VECTOR, default 0, first PC fetched after reset.
REQ-004 SHALL have parameter FETCH_DEPTH, default 2, prefetch buffer entries (power of 2, >=2).
REQ-005 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have ports imem_req_valid out 1, imem_req_ready in 1, imem_req_addr out XLEN: instruction-memory request handshake.
REQ-008 SHALL have ports imem_rsp_valid in 1, imem_rsp_data in INSTRUCTION_LENGTH: in-order responses, one per accepted request, latency >=1 cycle.
REQ-009 SHALL have ports redirect_valid in 1, redirect_target in XLEN: jump/branch redirect from the JBL.
REQ-010 SHALL have port f_to_d_enable_ff, input, 1, decode accepts the presented instruction when high.
REQ-011 SHALL have ports instruction out INSTRUCTION_LENGTH, fetch_pc out XLEN, fetch_valid out 1: to the fetch-to-decode register.
REQ-012 SHALL have port misaligned_fault, output, 1 (see Configuration).

Function
REQ-013 SHALL hold a PC register; a request fires when imem_req_valid && imem_req_ready, then PC <= PC+4.
REQ-014 SHALL assert imem_req_valid only in state RUN and when outstanding + buffer occupancy < FETCH_DEPTH (credit rule, no overflow possible).
REQ-015 SHALL keep imem_req_addr stable while imem_req_valid is high and ready low.
REQ-016 SHALL write each non-dropped response into the buffer as {pc of request, data}; output is registered, so data is visible at the outputs the cycle after imem_rsp_valid.
REQ-017 SHALL drive fetch_valid = buffer non-empty; instruction/fetch_pc from buffer head; instruction = NOP 32'h00000013 when empty.
REQ-018 SHALL pop the head when fetch_valid && f_to_d_enable_ff; with f_to_d_enable_ff low the outputs hold unchanged.
REQ-019 SHALL support simultaneous push and pop in one cycle with occupancy unchanged, including when full.
REQ-020 SHALL implement states RUN, DRAIN, HALT; RUN->DRAIN on redirect with responses outstanding; RUN->RUN on redirect with none outstanding; DRAIN->RUN when drop count reaches 0; HALT per Configuration.
REQ-021 On redirect_valid SHALL, in that cycle's edge: flush buffer, PC <= redirect_target, drop count <= outstanding requests including one firing that cycle, minus a response arriving that cycle.
REQ-022 In DRAIN SHALL discard responses, decrement drop count per response, and issue no requests.
REQ-023 Redirect SHALL win over pop/push in the same cycle; a redirect during DRAIN SHALL retarget PC and keep the drop count accounting exact.
REQ-024 PC arithmetic SHALL wrap modulo 2^XLEN.

Reset
REQ-025 On rst low, asynchronously: PC=RESET_VECTOR, state RUN, buffer empty, outstanding=0, drop count=0, imem_req_valid=0, fetch_valid=0, instruction=NOP, fetch_pc=0, misaligned_fault=0.
REQ-026 First request SHALL be presented in the first cycle after rst deasserts; reset mid-transaction SHALL discard all outstanding state (memory is reset concurrently).

Configuration
REQ-027 Macro FETCH_MISALIGN_TRAP_EN: defined -> redirect_target[1:0]!=0 sets misaligned_fault=1 (sticky), flushes, enters HALT (no requests, fetch_valid=0) until the next aligned redirect; undefined -> target[1:0] forced to 0, misaligned_fault tied 0, HALT unreachable.

Structure
REQ-028 Shared package riscv_pkg SHALL hold NOP_INSTR constant, fetch_entry_t {pc, instr} typedef and fetch_state_t enum.
REQ-029 Buffer SHALL be a sub-module fetch_buffer (parameterised FIFO, push/pop/flush, full/empty/count).

Verification
REQ-030 Reset release, ready=1, 1-cycle memory -> addresses 0,4,8 issued back-to-back; fetch_valid from cycle 3, pcs 0,4,8 in order.
REQ-031 f_to_d_enable_ff low 5 cycles -> at most 2 requests outstanding/buffered, outputs held, no response lost; resume -> pcs continue contiguously.
REQ-032 Redirect to 0x100 with 2 outstanding -> both responses dropped, next fetch_pc 0x100, no stale instruction presented.
REQ-033 imem_req_ready low 3 cycles -> imem_req_addr stable, single request accepted.
REQ-034 With FETCH_MISALIGN_TRAP_EN: redirect to 0x102 -> misaligned_fault=1, no requests; redirect to 0x200 -> fetch resumes at 0x200. Without: fetch from 0x100.
REQ-035 rst asserted mid-DRAIN -> all outputs to reset values immediately, fetch restarts at RESET_VECTOR.
